// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and helpers for the pcileech system-control block:
// LED mode encoding, per-channel mode extraction and the lit-state decode.
`timescale 1ns/1ps

package pcileech_sysctl_pkg;

  localparam int LED_MODE_W = 2;
  localparam int MAX_LED    = 8;
  localparam int MODE_BUS_W = LED_MODE_W * MAX_LED;

  typedef enum logic [1:0] {
    LED_LEVEL     = 2'b00,
    LED_STRETCH   = 2'b01,
    LED_HEARTBEAT = 2'b10,
    LED_OFF       = 2'b11
  } led_mode_t;

  // Pull channel ch's 2-bit mode out of the packed (zero-extended) mode bus.
  function automatic led_mode_t get_led_mode(input logic [MODE_BUS_W-1:0] mode_bus,
                                             input logic [2:0]            ch);
    return led_mode_t'(mode_bus[{ch, 1'b0} +: LED_MODE_W]);
  endfunction

  // Logical "LED is lit" for one channel, before invert and pad polarity.
  function automatic logic led_lit(input led_mode_t mode,
                                   input logic      src,
                                   input logic      stretch_active,
                                   input logic      beat);
    logic lit;
    case (mode)
      LED_LEVEL:     lit = src;
      LED_STRETCH:   lit = src | stretch_active;
      LED_HEARTBEAT: lit = src ^ beat;
      LED_OFF:       lit = 1'b0;
      default:       lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/pcileech_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a restartable
// stability counter. dout follows the synced level once it has differed from
// dout for DEBOUNCE_CYCLES consecutive cycles; rise pulses on the first dout=1.
`timescale 1ns/1ps

module pcileech_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous pad into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
    end else if (sync2_r != dout) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
        dout  <= sync2_r;
        rise  <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
        dout  <= dout;
        rise  <= 1'b0;
      end
    end else begin
      cnt_r <= '0;
      dout  <= dout;
      rise  <= 1'b0;
    end
  end

endmodule

// File: rtl/pcileech_sysctl.sv
// Board system control: power-on / button reset generation, button debounce,
// free-running 64-bit tickcount and multi-mode LED drivers. Only rst resets
// this block; rst_sys is for the downstream cores.
`timescale 1ns/1ps

module pcileech_sysctl
  import pcileech_sysctl_pkg::*;
#(
  parameter int                       PARAM_NUM_LED         = 3,
  parameter int                       PARAM_NUM_BTN         = 2,
  parameter logic [PARAM_NUM_BTN-1:0] PARAM_BTN_RST_MASK    = 2'b10,
  parameter int                       PARAM_POR_CYCLES      = 64,
  parameter int                       PARAM_DEBOUNCE_CYCLES = 1000000,
  parameter int                       PARAM_STRETCH_CYCLES  = 5000000,
  parameter int                       PARAM_HEARTBEAT_BIT   = 26,
  parameter bit                       PARAM_LED_ACTIVE_LOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PARAM_NUM_BTN-1:0]   btn_raw,
  input  logic [PARAM_NUM_LED-1:0]   led_src,
  input  logic [2*PARAM_NUM_LED-1:0] led_mode,
  input  logic [PARAM_NUM_LED-1:0]   led_invert,
  output logic                       rst_sys,
  output logic [PARAM_NUM_BTN-1:0]   btn_db,
  output logic [PARAM_NUM_BTN-1:0]   btn_press,
  output logic [63:0]                tickcount,
  output logic [PARAM_NUM_LED-1:0]   led_out
);

  // ---------------------------------------------------------------------
  // Reset generator constants
  // ---------------------------------------------------------------------
  localparam int            PW      = $clog2(PARAM_POR_CYCLES + 1);
  localparam logic [PW-1:0] POR_MAX = PW'(PARAM_POR_CYCLES);
  localparam logic [PW-1:0] POR_ONE = PW'(1);

  // ---------------------------------------------------------------------
  // Stretch counter constants
  // ---------------------------------------------------------------------
  localparam int            SW           = (PARAM_STRETCH_CYCLES > 0) ? $clog2(PARAM_STRETCH_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(PARAM_STRETCH_CYCLES);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);

  localparam logic [PARAM_NUM_LED-1:0] LED_POL = {PARAM_NUM_LED{PARAM_LED_ACTIVE_LOW}};

  logic [PW-1:0]              por_cnt_r;
  logic                       rst_btn_s;
  logic [MODE_BUS_W-1:0]      mode_bus_s;
  logic [PARAM_NUM_LED-1:0]   lit_s;

  // ---------------------------------------------------------------------
  // Free-running tick counter; natural 64-bit wrap.
  // ---------------------------------------------------------------------
  // Count every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tickcount <= 64'd0;
    end else begin
      tickcount <= tickcount + 64'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < PARAM_NUM_BTN; b++) begin : g_btn
    pcileech_debounce #(
      .DEBOUNCE_CYCLES (PARAM_DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_raw[b]),
      .dout (btn_db[b]),
      .rise (btn_press[b])
    );
  end

  // Any debounced reset-capable button held down.
  assign rst_btn_s = |(btn_db & PARAM_BTN_RST_MASK);

  // ---------------------------------------------------------------------
  // Reset generation
  // ---------------------------------------------------------------------
  // Power-on hold counter: restarts while a reset button is held, saturates at POR_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      por_cnt_r <= '0;
    end else if (rst_btn_s) begin
      por_cnt_r <= '0;
    end else if (por_cnt_r < POR_MAX) begin
      por_cnt_r <= por_cnt_r + POR_ONE;
    end else begin
      por_cnt_r <= por_cnt_r;
    end
  end

  // Registered system reset. The held-button term asserts it the cycle after
  // the press is seen (the counter itself only clears one cycle later) and
  // keeps it from dipping while the button is down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sys <= 1'b1;
    end else begin
      rst_sys <= (por_cnt_r < POR_MAX) | rst_btn_s;
    end
  end

  // ---------------------------------------------------------------------
  // LED channels
  // ---------------------------------------------------------------------
  // Zero-extend the packed mode bus to the package's fixed width.
  always_comb begin
    mode_bus_s                       = '0;
    mode_bus_s[2*PARAM_NUM_LED-1:0]  = led_mode;
  end

  for (genvar i = 0; i < PARAM_NUM_LED; i++) begin : g_led
    logic [SW-1:0] stretch_cnt_r;
    led_mode_t     mode_s;

    // Activity stretch: reload on source, else count down to zero. Runs in
    // every mode so switching to stretch shows already-pending activity.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stretch_cnt_r <= '0;
      end else if (led_src[i]) begin
        stretch_cnt_r <= STRETCH_LOAD;
      end else if (stretch_cnt_r != '0) begin
        stretch_cnt_r <= stretch_cnt_r - STRETCH_ONE;
      end else begin
        stretch_cnt_r <= '0;
      end
    end

    assign mode_s   = get_led_mode(mode_bus_s, 3'(i));
    assign lit_s[i] = led_lit(mode_s, led_src[i], (stretch_cnt_r != '0),
                              tickcount[PARAM_HEARTBEAT_BIT]);
  end

  // Pad drive: apply per-channel invert and board polarity, one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= LED_POL;
    end else begin
      led_out <= lit_s ^ led_invert ^ LED_POL;
    end
  end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Scoreboard bench for pcileech_sysctl. Stimulus pushes hand-derived
// expectations for the next sample point; a monitor drains and compares them
// one time unit after each rising clock (or on demand for async reset).
`timescale 1ns/1ps

module tb_pcileech_sysctl;

  typedef enum int {K_RST, K_DB, K_PRESS, K_LED, K_TICK} kind_t;

  typedef struct {
    kind_t       kind;
    int          idx;
    logic [63:0] val;
    string       tag;
  } exp_t;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [1:0]  btn_raw    = 2'b00;
  logic [2:0]  led_src    = 3'b000;
  logic [5:0]  led_mode   = 6'b000000;
  logic [2:0]  led_invert = 3'b000;
  logic        rst_sys;
  logic [1:0]  btn_db;
  logic [1:0]  btn_press;
  logic [63:0] tickcount;
  logic [2:0]  led_out;

  exp_t        sb_q[$];
  event        sample_ev;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] tick_m = 64'd0;
  exp_t        mon_e;
  logic [63:0] mon_got;

  pcileech_sysctl #(
    .PARAM_NUM_LED         (3),
    .PARAM_NUM_BTN         (2),
    .PARAM_BTN_RST_MASK    (2'b10),
    .PARAM_POR_CYCLES      (8),
    .PARAM_DEBOUNCE_CYCLES (4),
    .PARAM_STRETCH_CYCLES  (10),
    .PARAM_HEARTBEAT_BIT   (3),
    .PARAM_LED_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .led_src    (led_src),
    .led_mode   (led_mode),
    .led_invert (led_invert),
    .rst_sys    (rst_sys),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .tickcount  (tickcount),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // Sample point: 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    ->sample_ev;
  end

  // Monitor: compare every pending expectation against the DUT.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        case (mon_e.kind)
          K_RST:   mon_got = {63'd0, rst_sys};
          K_DB:    mon_got = {62'd0, btn_db};
          K_PRESS: mon_got = {62'd0, btn_press};
          K_LED:   mon_got = {63'd0, led_out[mon_e.idx]};
          K_TICK:  mon_got = tickcount;
          default: mon_got = 64'hxxxx_xxxx_xxxx_xxxx;
        endcase
        n_vec++;
        if (mon_got !== mon_e.val) begin
          n_err++;
          $display("FAIL %s: got %0h, expected %0h (t=%0t)", mon_e.tag, mon_got, mon_e.val, $time);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  function automatic logic [63:0] two(input logic b1, input logic b0);
    return {62'd0, b1, b0};
  endfunction

  task automatic expect_val(input kind_t k, input int idx, input logic [63:0] v, input string tag);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_val(K_RST, 0, 64'd1, {tag, "_rst_sys"});
    expect_val(K_DB, 0, 64'd0, {tag, "_btn_db"});
    expect_val(K_PRESS, 0, 64'd0, {tag, "_btn_press"});
    for (int i = 0; i < 3; i++) expect_val(K_LED, i, 64'd1, {tag, "_led"});
  endtask

  // One clock: model tickcount for the coming edge, then move past it.
  task automatic advance();
    if (rst) tick_m = 64'd0;
    else     tick_m = tick_m + 64'd1;
    expect_val(K_TICK, 0, tick_m, "tickcount");
    @(posedge clk);
    #2;
  endtask

  task automatic sample_now();
    #1;
    ->sample_ev;
    #1;
  endtask

  int last_pulse;

  initial begin
    // Power-on: rst held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      expect_reset_vals("por_hold");
      advance();
    end
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      expect_val(K_RST, 0, 64'(j < 9), "por_release_rst_sys");
      advance();
    end

    // Reset button with bounce: 1,1,0,0 then held; released after 20 cycles.
    for (int b = 0; b < 4; b++) begin
      btn_raw[1] = (b < 2);
      expect_val(K_DB, 0, 64'd0, "bounce_btn_db");
      expect_val(K_PRESS, 0, 64'd0, "bounce_btn_press");
      expect_val(K_RST, 0, 64'd0, "bounce_rst_sys");
      advance();
    end
    for (int k = 1; k <= 38; k++) begin
      btn_raw[1] = (k <= 20);
      expect_val(K_DB, 0, two((k >= 6) && (k < 26), 1'b0), "rstbtn_btn_db");
      expect_val(K_PRESS, 0, two(k == 6, 1'b0), "rstbtn_btn_press");
      expect_val(K_RST, 0, 64'((k >= 7) && (k < 35)), "rstbtn_rst_sys");
      advance();
    end

    // Unmasked button: debounces but never touches rst_sys.
    for (int k = 1; k <= 20; k++) begin
      btn_raw[0] = (k <= 10);
      expect_val(K_DB, 0, two(1'b0, (k >= 6) && (k < 16)), "btn0_btn_db");
      expect_val(K_PRESS, 0, two(1'b0, k == 6), "btn0_btn_press");
      expect_val(K_RST, 0, 64'd0, "btn0_rst_sys");
      advance();
    end

    // LEDs: ch0 stretch, ch1 level, ch2 heartbeat.
    led_mode = 6'b10_00_01;
    expect_val(K_LED, 0, 64'd1, "stretch_idle_led0");
    advance();
    last_pulse = -100;
    for (int n = 0; n < 42; n++) begin
      led_src[0] = (n == 0) || (n == 20) || (n == 25);
      led_src[1] = ((n >> 1) & 1) != 0;
      if (led_src[0]) last_pulse = n;
      expect_val(K_LED, 0, 64'(!((n - last_pulse) <= 10)), "stretch_led0");
      expect_val(K_LED, 1, 64'(!led_src[1]), "level_led1");
      expect_val(K_LED, 2, 64'(!tick_m[3]), "heartbeat_led2");
      advance();
    end
    led_src = 3'b000;

    // Heartbeat with invert: phase flips from the next edge.
    led_invert[2] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      expect_val(K_LED, 2, 64'(tick_m[3]), "hb_invert_led2");
      expect_val(K_LED, 0, 64'd1, "hb_invert_led0");
      advance();
    end

    // Off mode ignores source and heartbeat.
    led_mode[5:4] = 2'b11;
    led_invert[2] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      led_src[2] = (n & 1) != 0;
      expect_val(K_LED, 2, 64'd1, "off_led2");
      advance();
    end
    led_src[2] = 1'b0;

    // Async reset during stretch and debounce counting.
    led_src[0] = 1'b1;
    btn_raw[0] = 1'b1;
    advance();
    led_src[0] = 1'b0;
    expect_val(K_LED, 0, 64'd0, "pre_async_led0");
    advance();
    advance();
    rst    = 1'b1;
    tick_m = 64'd0;
    expect_reset_vals("async_rst");
    expect_val(K_TICK, 0, 64'd0, "async_rst_tickcount");
    sample_now();
    for (int i = 0; i < 2; i++) begin
      expect_reset_vals("async_hold");
      advance();
    end
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      expect_val(K_RST, 0, 64'(j < 9), "restart_rst_sys");
      expect_val(K_DB, 0, two(1'b0, j >= 6), "restart_btn_db");
      expect_val(K_PRESS, 0, two(1'b0, j == 6), "restart_btn_press");
      expect_val(K_LED, 0, 64'd1, "restart_led0");
      advance();
    end
    btn_raw = 2'b00;

    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      n_err = n_err + sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
